// File: rtl/mem_line_fill.sv
// mem_line_fill: sits between a cache and a narrow memory bus.
// A line read is broken into BEATS bus beats that are assembled into one line.
// A word write goes out as a single bus request. Every completed request is
// reported back to the cache with a one-cycle mem_data_valid pulse.
module mem_line_fill #(
    parameter int BLOCKSZ     = 512,
    parameter int WIDTH       = 64,
    parameter int ADDRESSSIZE = 64,
    parameter int BEATS       = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_req,
    input  logic [ADDRESSSIZE-1:0] mem_address,
    input  logic                   mem_wr_en,
    input  logic [WIDTH-1:0]       mem_data_out,
    output logic [BLOCKSZ-1:0]     mem_data_in,
    output logic                   mem_data_valid,
    output logic                   busy,
    output logic                   bus_req,
    output logic [ADDRESSSIZE-1:0] bus_reqaddr,
    output logic                   bus_reqwrite,
    output logic [WIDTH-1:0]       bus_reqdata,
    input  logic                   bus_reqack,
    input  logic [WIDTH-1:0]       bus_resp,
    input  logic                   bus_respcyc,
    output logic                   bus_respack
);

    localparam int CNTW     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LINE_OFF = $clog2(BLOCKSZ / 8);
    localparam int WORD_OFF = $clog2(WIDTH / 8);

    // Masks that clear the byte offset within a line (reads) or within a word (writes).
    localparam logic [ADDRESSSIZE-1:0] LINE_MASK = {{(ADDRESSSIZE - LINE_OFF){1'b1}}, {LINE_OFF{1'b0}}};
    localparam logic [ADDRESSSIZE-1:0] WORD_MASK = {{(ADDRESSSIZE - WORD_OFF){1'b1}}, {WORD_OFF{1'b0}}};
    localparam logic [CNTW-1:0]        LAST_BEAT = CNTW'(BEATS - 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_REQ  = 3'd1;
    localparam logic [2:0] RD_DATA = 3'd2;
    localparam logic [2:0] WR_REQ  = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

    logic [2:0]             state;
    logic [CNTW-1:0]        beat_cnt;
    logic [ADDRESSSIZE-1:0] addr_q;
    logic [WIDTH-1:0]       data_q;
    logic [BLOCKSZ-1:0]     line_q;

    // Control FSM; new requests are only looked at in IDLE, so nothing is queued while busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (mem_req) state <= mem_wr_en ? WR_REQ : RD_REQ;
                RD_REQ:  if (bus_reqack) state <= RD_DATA;
                RD_DATA: if (bus_respcyc && beat_cnt == LAST_BEAT) state <= DONE;
                WR_REQ:  if (bus_reqack) state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Request capture: address is aligned at accept time so the bus only ever sees aligned addresses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            data_q <= '0;
        end else if (state == IDLE && mem_req) begin
            if (mem_wr_en) begin
                addr_q <= mem_address & WORD_MASK;
                data_q <= mem_data_out;
            end else begin
                addr_q <= mem_address & LINE_MASK;
            end
        end
    end

    // Beat counter: cleared when the read request is accepted, advances on each accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if (state == RD_REQ && bus_reqack) begin
            beat_cnt <= '0;
        end else if (state == RD_DATA && bus_respcyc) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

    // Line assembly: the returned line changes only when a read beat lands, so writes leave it intact.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_q <= '0;
        end else if (state == RD_DATA && bus_respcyc) begin
            line_q[beat_cnt*WIDTH +: WIDTH] <= bus_resp;
        end
    end

    assign mem_data_in    = line_q;
    assign mem_data_valid = (state == DONE);
    assign busy           = (state != IDLE);
    assign bus_req        = (state == RD_REQ) || (state == WR_REQ);
    assign bus_reqwrite   = (state == WR_REQ);
    assign bus_reqaddr    = addr_q;
    assign bus_reqdata    = data_q;
    assign bus_respack    = (state == RD_DATA) && bus_respcyc;

endmodule

// File: tb/tb_mem_line_fill.sv
// tb_mem_line_fill: drives the cache side and plays a bus responder with
// configurable ack delay and beat gaps. Expected results come from a
// transaction-level model (aligned address, latency arithmetic, returned line).
module tb_mem_line_fill;

    logic         clk = 1'b0;
    logic         rst;
    logic         mem_req;
    logic [63:0]  mem_address;
    logic         mem_wr_en;
    logic [63:0]  mem_data_out;
    logic [511:0] mem_data_in;
    logic         mem_data_valid;
    logic         busy;
    logic         bus_req;
    logic [63:0]  bus_reqaddr;
    logic         bus_reqwrite;
    logic [63:0]  bus_reqdata;
    logic         bus_reqack;
    logic [63:0]  bus_resp;
    logic         bus_respcyc;
    logic         bus_respack;

    int checks = 0;
    int errors = 0;
    logic [511:0] model_line = '0;

    typedef struct {
        logic         wr;
        logic [63:0]  addr;
        logic [63:0]  wdata;
        int           ack_delay;
        logic [6:0]   gaps;
        logic [511:0] line;
        logic [63:0]  exp_addr;
        int           exp_lat;
    } txn_t;

    txn_t vec [5];

    mem_line_fill dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req        (mem_req),
        .mem_address    (mem_address),
        .mem_wr_en      (mem_wr_en),
        .mem_data_out   (mem_data_out),
        .mem_data_in    (mem_data_in),
        .mem_data_valid (mem_data_valid),
        .busy           (busy),
        .bus_req        (bus_req),
        .bus_reqaddr    (bus_reqaddr),
        .bus_reqwrite   (bus_reqwrite),
        .bus_reqdata    (bus_reqdata),
        .bus_reqack     (bus_reqack),
        .bus_resp       (bus_resp),
        .bus_respcyc    (bus_respcyc),
        .bus_respack    (bus_respack)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Hard time limit so a stuck design still ends the run.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_word(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_output(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: aligned bus address and completion latency from the transaction parameters.
    function automatic txn_t model_expect(input txn_t t);
        txn_t r = t;
        r.exp_addr = t.wr ? {t.addr[63:3], 3'b000} : {t.addr[63:6], 6'b000000};
        r.exp_lat  = t.wr ? t.ack_delay + 2 : t.ack_delay + 10 + $countones(t.gaps);
        return r;
    endfunction

    // Random cache-side traffic while the block is busy; it must all be ignored.
    task automatic cache_noise();
        mem_req      = 1'($urandom_range(0, 1));
        mem_wr_en    = 1'($urandom_range(0, 1));
        mem_address  = {$urandom, $urandom};
        mem_data_out = {$urandom, $urandom};
    endtask

    // One full transaction: request, bus handshake, beats, then a bounded wait for completion.
    task automatic apply_stimulus(input int idx, input txn_t t);
        int cyc;
        logic seen;
        mem_req      = 1'b1;
        mem_wr_en    = t.wr;
        mem_address  = t.addr;
        mem_data_out = t.wdata;
        bus_reqack   = 1'b0;
        bus_respcyc  = 1'b0;
        @(negedge clk);
        check_bit($sformatf("t%0d idle before accept", idx), busy, 1'b0);
        tick();
        cyc = 0;
        for (int d = 0; d <= t.ack_delay; d++) begin
            cache_noise();
            bus_reqack = (d == t.ack_delay);
            @(negedge clk);
            check_bit($sformatf("t%0d bus_req", idx), bus_req, 1'b1);
            check_word($sformatf("t%0d bus_reqaddr", idx), bus_reqaddr, t.exp_addr);
            check_bit($sformatf("t%0d bus_reqwrite", idx), bus_reqwrite, t.wr);
            if (t.wr) check_word($sformatf("t%0d bus_reqdata", idx), bus_reqdata, t.wdata);
            check_bit($sformatf("t%0d valid in req", idx), mem_data_valid, 1'b0);
            tick();
            cyc++;
        end
        bus_reqack = 1'b0;
        if (!t.wr) begin
            for (int b = 0; b < 8; b++) begin
                if (b > 0 && t.gaps[b-1]) begin
                    cache_noise();
                    bus_respcyc = 1'b0;
                    bus_resp    = {$urandom, $urandom};
                    @(negedge clk);
                    check_bit($sformatf("t%0d respack in gap", idx), bus_respack, 1'b0);
                    tick();
                    cyc++;
                end
                cache_noise();
                bus_respcyc = 1'b1;
                bus_resp    = t.line[b*64 +: 64];
                @(negedge clk);
                check_bit($sformatf("t%0d respack beat %0d", idx, b), bus_respack, 1'b1);
                check_bit($sformatf("t%0d bus_req in data", idx), bus_req, 1'b0);
                check_bit($sformatf("t%0d valid in data", idx), mem_data_valid, 1'b0);
                tick();
                cyc++;
            end
            model_line = t.line;
        end
        mem_req     = 1'b0;
        bus_respcyc = 1'($urandom_range(0, 1));
        bus_resp    = {$urandom, $urandom};
        seen = 1'b0;
        for (int w = 0; w < 20 && !seen; w++) begin
            @(negedge clk);
            if (mem_data_valid) seen = 1'b1;
            else begin
                tick();
                cyc++;
            end
        end
        check_bit($sformatf("t%0d valid seen", idx), seen, 1'b1);
        check_word($sformatf("t%0d latency", idx), 64'(cyc + 1), 64'(t.exp_lat));
        check_output($sformatf("t%0d mem_data_in", idx), mem_data_in, model_line);
        check_bit($sformatf("t%0d respack in done", idx), bus_respack, 1'b0);
        check_bit($sformatf("t%0d bus_req in done", idx), bus_req, 1'b0);
        tick();
        bus_respcyc = 1'b0;
        @(negedge clk);
        check_bit($sformatf("t%0d valid one cycle", idx), mem_data_valid, 1'b0);
        check_bit($sformatf("t%0d back to idle", idx), busy, 1'b0);
        tick();
    endtask

    // Stray beats while idle must not be acknowledged or stored.
    task automatic idle_beats();
        mem_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus_respcyc = 1'b1;
            bus_resp    = {$urandom, $urandom};
            @(negedge clk);
            check_bit("idle respack", bus_respack, 1'b0);
            check_bit("idle busy", busy, 1'b0);
            check_output("idle line hold", mem_data_in, model_line);
            tick();
        end
        bus_respcyc = 1'b0;
    endtask

    // Reset in the middle of a read: outputs clear at once and the read never completes.
    task automatic reset_mid_read();
        logic bad_valid;
        mem_req     = 1'b1;
        mem_wr_en   = 1'b0;
        mem_address = 64'h0000_0000_0000_4010;
        tick();
        mem_req    = 1'b0;
        bus_reqack = 1'b1;
        tick();
        bus_reqack = 1'b0;
        for (int b = 0; b < 5; b++) begin
            bus_respcyc = 1'b1;
            bus_resp    = 64'hA5A5_0000_0000_0000 | 64'(b);
            tick();
        end
        #1;
        check_bit("pre-reset busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        model_line = '0;
        check_bit("rst busy", busy, 1'b0);
        check_bit("rst respack", bus_respack, 1'b0);
        check_bit("rst bus_req", bus_req, 1'b0);
        check_bit("rst valid", mem_data_valid, 1'b0);
        check_word("rst reqaddr", bus_reqaddr, 64'h0);
        check_output("rst line", mem_data_in, model_line);
        bus_respcyc = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        bad_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (mem_data_valid || busy) bad_valid = 1'b1;
            tick();
        end
        check_bit("no activity after reset", bad_valid, 1'b0);
    endtask

    initial begin
        rst          = 1'b1;
        mem_req      = 1'b0;
        mem_address  = '0;
        mem_wr_en    = 1'b0;
        mem_data_out = '0;
        bus_reqack   = 1'b0;
        bus_resp     = '0;
        bus_respcyc  = 1'b0;

        // Directed vectors with hand-derived expectations.
        vec[0] = '{wr: 1'b0, addr: 64'h0000_1234_5678_9ABC, wdata: 64'h0, ack_delay: 0, gaps: 7'b0,
                   line: '0, exp_addr: 64'h0000_1234_5678_9A80, exp_lat: 10};
        vec[1] = '{wr: 1'b1, addr: 64'h0000_0000_1000_0008, wdata: 64'h0000_0000_DEAD_BEEF, ack_delay: 3,
                   gaps: 7'b0, line: '0, exp_addr: 64'h0000_0000_1000_0008, exp_lat: 5};
        vec[2] = '{wr: 1'b0, addr: 64'h0000_0000_0000_2047, wdata: 64'h0, ack_delay: 1, gaps: 7'b0100100,
                   line: '0, exp_addr: 64'h0000_0000_0000_2040, exp_lat: 13};
        vec[3] = '{wr: 1'b1, addr: 64'hFFFF_FFFF_FFFF_FFFF, wdata: 64'h0123_4567_89AB_CDEF, ack_delay: 0,
                   gaps: 7'b0, line: '0, exp_addr: 64'hFFFF_FFFF_FFFF_FFF8, exp_lat: 2};
        vec[4] = '{wr: 1'b0, addr: 64'hFFFF_FFFF_FFFF_FFFF, wdata: 64'h0, ack_delay: 2, gaps: 7'b0,
                   line: '0, exp_addr: 64'hFFFF_FFFF_FFFF_FFC0, exp_lat: 12};
        for (int b = 0; b < 8; b++) begin
            vec[0].line[b*64 +: 64] = 64'(b + 1) * 64'h11;
            vec[2].line[b*64 +: 64] = 64'hC0DE_0000_0000_0000 | 64'(b * 3 + 7);
            vec[4].line[b*64 +: 64] = ~(64'(b) << 8);
        end

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_bit("reset busy", busy, 1'b0);
        check_bit("reset valid", mem_data_valid, 1'b0);
        check_bit("reset bus_req", bus_req, 1'b0);
        check_bit("reset reqwrite", bus_reqwrite, 1'b0);
        check_bit("reset respack", bus_respack, 1'b0);
        check_word("reset reqaddr", bus_reqaddr, 64'h0);
        check_word("reset reqdata", bus_reqdata, 64'h0);
        check_output("reset line", mem_data_in, model_line);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) apply_stimulus(i, vec[i]);

        idle_beats();
        reset_mid_read();
        apply_stimulus(5, vec[0]);

        // Randomized transactions checked against the model.
        for (int i = 0; i < 16; i++) begin
            txn_t t;
            t.wr        = 1'($urandom_range(0, 1));
            t.addr      = {$urandom, $urandom};
            t.wdata     = {$urandom, $urandom};
            t.ack_delay = int'($urandom_range(0, 3));
            t.gaps      = 7'($urandom);
            for (int b = 0; b < 16; b++) t.line[b*32 +: 32] = $urandom;
            t = model_expect(t);
            apply_stimulus(100 + i, t);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
